// File: rtl/redux_v_multiciclo.sv
// rtl/redux_v_multiciclo.sv - multicycle Redux-V core with handshaked instruction/data memories
//
// Purpose: executes 8-bit Redux-V instructions over a 4-entry register file using a
// FETCH/EXEC/MEM/WB/HALT state machine. Both memories sit outside the core behind
// req/ready handshakes, so the core stalls for as long as a memory withholds ready.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   imem_req/addr            fetch request, address = pc
//   imem_ready/data          fetch completion and instruction word
//   dmem_req/we/addr/wdata   data request (we=1 store), address = R[rb], data = R[ra]
//   dmem_ready/rdata         data completion and load data
//   halted                   core sits in HALT
//   pc_out                   current pc for debug
module redux_v_multiciclo #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [7:0]       imem_data,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ready,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             halted,
    output logic [WIDTH-1:0] pc_out
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_pc;
    logic [7:0]       r_ir;
    logic [WIDTH-1:0] r_regs [0:3];
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_dmem_addr;
    logic [WIDTH-1:0] r_dmem_wdata;
    logic             r_dmem_we;

    logic [3:0]       w_op;
    logic [1:0]       w_ra;
    logic [1:0]       w_rb;
    logic [1:0]       w_wb_idx;
    logic [WIDTH-1:0] w_rra;
    logic [WIDTH-1:0] w_rrb;
    logic [WIDTH-1:0] w_sext;
    logic [WIDTH-1:0] w_zext;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_br_pc;
    logic             w_is_alu;
    logic             w_is_mem;

    assign w_op     = r_ir[7:4];
    assign w_ra     = r_ir[3:2];
    assign w_rb     = r_ir[1:0];
    assign w_rra    = r_regs[w_ra];
    assign w_rrb    = r_regs[w_rb];
    assign w_sext   = {{(WIDTH-4){r_ir[3]}}, r_ir[3:0]};
    assign w_zext   = {{(WIDTH-4){1'b0}}, r_ir[3:0]};
    assign w_pc_inc = r_pc + C_ONE;
    // Opcodes 8..F are all register-writing ALU operations.
    assign w_is_alu = w_op[3];
    assign w_is_mem = (w_op == 4'h4) || (w_op == 4'h5);
    // ADDI always targets R0; every other writer targets R[ra].
    assign w_wb_idx = (w_op == 4'h8) ? 2'd0 : w_ra;

    always_comb begin
        w_alu = '0;
        case (w_op)
            4'h8:    w_alu = r_regs[0] + w_sext;
            4'h9:    w_alu = ~w_rrb;
            4'hA:    w_alu = w_rra & w_rrb;
            4'hB:    w_alu = w_rra | w_rrb;
            4'hC:    w_alu = w_rra ^ w_rrb;
            4'hD:    w_alu = w_rra + w_rrb;
            4'hE:    w_alu = w_rra - w_rrb;
            4'hF:    w_alu = w_rrb << 1;
            default: w_alu = '0;
        endcase
    end

    // Next pc for branches; NOPs and not-taken branches fall through.
    always_comb begin
        w_br_pc = w_pc_inc;
        case (w_op)
            4'h0:    w_br_pc = (w_rra == '0) ? w_rrb : w_pc_inc;
            4'h1:    w_br_pc = (r_regs[0] == '0) ? (r_pc + w_zext) : w_pc_inc;
            4'h2:    w_br_pc = r_pc + w_sext;
            default: w_br_pc = w_pc_inc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_pc         <= '0;
            r_ir         <= '0;
            r_result     <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_we    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_data;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_is_alu) begin
                        r_result <= w_alu;
                        r_state  <= S_WB;
                    end else if (w_is_mem) begin
                        // Registered here so the bus stays stable for the whole wait.
                        r_dmem_addr  <= w_rrb;
                        r_dmem_wdata <= w_rra;
                        r_dmem_we    <= (w_op == 4'h5);
                        r_state      <= S_MEM;
                    end else if (w_op == 4'h7) begin
                        r_state <= S_HALT;
                    end else begin
                        r_pc    <= w_br_pc;
                        r_state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (r_dmem_we) begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end else begin
                            r_regs[w_ra] <= dmem_rdata;
                            r_state      <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    // A load already wrote its register on the ready edge.
                    if (w_op != 4'h4) begin
                        r_regs[w_wb_idx] <= r_result;
                    end
                    r_pc    <= w_pc_inc;
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Requests are gated by reset so an in-flight access is dropped at once.
    assign imem_req   = (r_state == S_FETCH) && !reset;
    assign dmem_req   = (r_state == S_MEM) && !reset;
    assign dmem_we    = r_dmem_we && dmem_req;
    assign halted     = (r_state == S_HALT) && !reset;
    assign imem_addr  = r_pc;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign pc_out     = r_pc;

endmodule
